ffe_slicer: RTL
===============

# ffe_slicer

PAM4 decision slicer and error monitor sitting directly downstream of the 4-tap FFE. It takes each equalized 12-bit signed Q6.6 sample (data plus single-cycle valid strobe), slices it to one of four PAM4 levels, and queues the 2-bit Gray symbol in a 4-deep valid/ready FIFO for the consumer. It also computes the slicer error, and reports the sum of absolute error over a fixed window as the equalizer-quality metric.

## Interface
- LVL, 128, PAM4 unit level L in Q6.6 (128 = 2.0); levels are ±L, ±3L; legal range 1..682
- WIN, 16, samples per error window; power of two, 2..256
- Derived (localparam, not overridable): SUM_W = 13 + log2(WIN)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- din  in  12  signed Q6.6 FFE output sample
- din_valid  in  1  one-cycle strobe per new sample
- clr  in  1  synchronous; restarts error window, clears overflow
- sym  out  2  FIFO head symbol: -3L=00, -L=01, +L=11, +3L=10
- sym_valid  out  1  FIFO non-empty
- sym_ready  in  1  consumer accepts head when sym_valid & sym_ready
- err_sum  out  SUM_W  unsigned sum of |err| for last completed window
- err_valid  out  1  one-cycle pulse when err_sum updates
- overflow  out  1  sticky; a symbol was dropped on a full FIFO

## Operation
- Thresholds at -2L, 0, +2L; comparison is >=, ties go to the upper level:
  - din >= 2L → +3L
  - 0 <= din < 2L → +L
  - -2L <= din < 0 → -L
  - din < -2L → -3L
- err = din - level, computed in 13-bit signed with no saturation; |err| is 13-bit unsigned.
- Stage 1 (S1) is registered when din_valid is high and holds sym, |err| and a valid bit.
- Stage 2, on the edge after S1 valid:
  - the symbol is written to the FIFO;
  - |err| is added to the accumulator;
  - the window counter increments.
- Window handling:
  - The window counter runs 0..WIN-1.
  - On the sample that completes the window, err_sum <= acc + |err| and err_valid pulses.
  - The accumulator and counter then restart from 0 for the next window.
- FIFO: 4 entries, first-word fall-through, in-order delivery.
  - Write when full and no read in the same cycle: the symbol is dropped, FIFO contents are unchanged, overflow is set.
  - Write and read in the same cycle when full: both succeed, overflow is not set.
  - sym_ready while empty is ignored.
- clr:
  - Zeroes the accumulator, the window counter and overflow on the next edge.
  - A sample reaching stage 2 in the same cycle is excluded from the window.
  - The FIFO is not flushed; the in-flight S1 symbol is still written.
  - err_sum keeps its last value.
- Reset (async, any time, including mid-window):
  - S1 valid=0, FIFO empty, counter=0, accumulator=0.
  - Outputs: sym=00, sym_valid=0, err_sum=0, err_valid=0, overflow=0.

## Timing
- din_valid high in cycle n:
  - S1 is loaded at edge n+1.
  - The FIFO write and accumulator add happen at edge n+2.
  - sym_valid rises after edge n+2 if the FIFO was empty (latency 2).
- err_valid is high in the cycle after the edge at which the WIN-th sample is added; err_sum is valid in that same cycle.
- Back-to-back din_valid every cycle is supported at full throughput as long as sym_ready is held high.
- The FFE produces a sample every 4th clock or slower; the block must not assume that spacing.
- FIFO count, sym_valid and overflow are all registered outputs; there is no combinational path from sym_ready to sym_valid.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with random din/din_valid, then release.
  - Required: sym_valid=0, err_sum=0, err_valid=0, overflow=0 throughout, and no FIFO writes.
- Slicing:
  - Stimulus: with LVL=128 and sym_ready=1, send din = 480, -100, 0, -256, 255, -300.
  - Required: sym = 10, 01, 11, 01, 11, 00 and |err| = 96, 28, 128, 128, 127, 84, each appearing 2 cycles after its strobe.
- Window:
  - Stimulus: with WIN=16, send 16 samples of din=480 spaced 4 cycles apart.
  - Required: exactly one err_valid pulse, err_sum=1536; a 17th sample produces no pulse.
- FIFO full:
  - Stimulus: sym_ready=0, send 5 samples (480, 400, 758, 0, -300).
  - Required: FIFO holds 10, 10, 10, 11 and overflow=1. Then set sym_ready=1; the 4 symbols drain in order, and overflow stays 1 until clr.
- Full with concurrent read:
  - Stimulus: fill the FIFO, then assert sym_ready in the same cycle a 5th symbol is written.
  - Required: overflow=0, count stays 4, and the new symbol is delivered last.
- Reset mid-window and clr:
  - Stimulus: pulse rst low after 7 samples, then send 16 samples; separately, assert clr after 9 samples, then send 16.
  - Required: in both cases err_valid fires only after the 16 post-event samples.

Source files
------------

// File: rtl/ffe_slicer.sv
// PAM4 decision slicer with symbol FIFO and windowed error monitor.
// Ports: clk, rst(async low), din/din_valid/clr in; sym/sym_valid/sym_ready FIFO; err_sum/err_valid/overflow.
module ffe_slicer #(
  parameter int LVL = 128,
  parameter int WIN = 16,
  localparam int SUM_W = 13 + $clog2(WIN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] din,
  input  logic               din_valid,
  input  logic               clr,
  output logic [1:0]         sym,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic [SUM_W-1:0]   err_sum,
  output logic               err_valid,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIN);

  localparam logic signed [12:0] L1 = 13'(LVL);
  localparam logic signed [12:0] L2 = 13'(2 * LVL);
  localparam logic signed [12:0] L3 = 13'(3 * LVL);

  typedef struct packed {
    logic        vld;
    logic [1:0]  sym;
    logic [12:0] mag;
  } s1_t;

  // ---------------- slicer ----------------
  logic signed [12:0] d13;
  logic signed [12:0] lvl;
  logic signed [12:0] err;
  logic [1:0]         code;
  logic [12:0]        mag;

  assign d13 = {din[11], din};

  always_comb begin
    code = 2'b00;
    lvl  = -L3;
    unique case (1'b1)
      (d13 >= L2): begin
        code = 2'b10;
        lvl  = L3;
      end
      (d13 >= 13'sd0 && d13 < L2): begin
        code = 2'b11;
        lvl  = L1;
      end
      (d13 >= -L2 && d13 < 13'sd0): begin
        code = 2'b01;
        lvl  = -L1;
      end
      (d13 < -L2): begin
        code = 2'b00;
        lvl  = -L3;
      end
    endcase
  end

  // Wraps in 13 bits by design; legal LVL keeps it in range.
  assign err = d13 - lvl;
  assign mag = err[12] ? 13'(-err) : 13'(err);

  // ---------------- stage 1 ----------------
  s1_t s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
    end else begin
      s1.vld <= din_valid;
      if (din_valid) begin
        s1.sym <= code;
        s1.mag <= mag;
      end
    end
  end

  // ---------------- error window ----------------
  logic [CNT_W-1:0] wcnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic             wlast;

  assign acc_nxt = acc + SUM_W'(s1.mag);
  assign wlast   = (wcnt == CNT_W'(WIN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      acc       <= '0;
      err_sum   <= '0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      // clr drops any sample arriving on the same edge.
      if (clr) begin
        wcnt <= '0;
        acc  <= '0;
      end else if (s1.vld) begin
        if (wlast) begin
          err_sum   <= acc_nxt;
          err_valid <= 1'b1;
          wcnt      <= '0;
          acc       <= '0;
        end else begin
          acc  <= acc_nxt;
          wcnt <= wcnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- symbol FIFO ----------------
  logic [1:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] fcnt;
  logic [2:0] fcnt_nxt;
  logic       full;
  logic       rd;
  logic       wr;
  logic       wr_ok;

  assign full  = (fcnt == 3'd4);
  assign rd    = sym_ready & sym_valid;
  assign wr    = s1.vld;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign wr_ok = wr & (~full | rd);
  assign sym   = mem[rp];

  always_comb begin
    fcnt_nxt = fcnt;
    unique case ({wr_ok, rd})
      2'b10:   fcnt_nxt = fcnt + 3'd1;
      2'b01:   fcnt_nxt = fcnt - 3'd1;
      default: fcnt_nxt = fcnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 2'b00;
      wp        <= '0;
      rp        <= '0;
      fcnt      <= '0;
      sym_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wp] <= s1.sym;
        wp      <= wp + 2'd1;
      end
      if (rd) rp <= rp + 2'd1;
      fcnt      <= fcnt_nxt;
      sym_valid <= (fcnt_nxt != 3'd0);
      if (clr) overflow <= 1'b0;
      else if (wr & full & ~rd) overflow <= 1'b1;
    end
  end

endmodule
